dmem_store_rmw: RTL

- Narrowing store path for the MIPS CPU data-memory port: the inverse of load-side sign/zero extension.
- Takes a 32-bit register value and a store type (SW/SH/SB), selects the low byte or halfword, and places it in the addressed byte lane.
- The data memory has no byte enables, so SH/SB run a read-modify-write sequence over a req/ack memory handshake. SW writes directly.
- Sits between the EX/MEM stage and the data memory; the CPU stalls while busy=1.

---
 rtl/dmem_store_rmw_if.sv | 29 ++
 rtl/dmem_store_rmw.sv | 100 ++++++++++
 2 files changed

// File: rtl/dmem_store_rmw_if.sv
// rtl/dmem_store_rmw_if.sv - CPU-side store request and data-memory handshake bundle.
interface dmem_store_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        store_type;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              addr_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // master: the CPU pipeline together with the data memory it talks to
    modport master (
        output start, store_type, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, addr_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  start, store_type, addr, wdata, mem_rdata, mem_ack,
        output busy, done, addr_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_store_rmw.sv
// rtl/dmem_store_rmw.sv - SW/SH/SB store path with read-modify-write on a word-only data memory.
module dmem_store_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_store_rmw_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_READ  = 2'b01;
    localparam logic [1:0] S_WRITE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    logic [1:0]        state;
    logic [1:0]        type_q;
    logic [1:0]        lane_q;
    logic [15:0]       half_q;
    logic              err_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              reject;
    logic [31:0]       merged;

    always_comb begin
        reject = 1'b0;
        case (bus.store_type)
            ST_SW:   reject = (bus.addr[1:0] != 2'b00);
            ST_SH:   reject = bus.addr[0];
            ST_SB:   reject = 1'b0;
            default: reject = 1'b1;
        endcase
    end

    // Only the low halfword of rt is ever needed once the store is narrowed.
    always_comb begin
        merged = bus.mem_rdata;
        if (type_q == ST_SB)
            merged[{lane_q, 3'b000} +: 8] = half_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = half_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            type_q  <= 2'b00;
            lane_q  <= 2'b00;
            half_q  <= 16'h0000;
            err_q   <= 1'b0;
            word_q  <= 32'h0000_0000;
            maddr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        type_q  <= bus.store_type;
                        lane_q  <= bus.addr[1:0];
                        half_q  <= bus.wdata[15:0];
                        maddr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                        err_q   <= reject;
                        if (reject) begin
                            state <= S_DONE;
                        end else if (bus.store_type == ST_SW) begin
                            word_q <= bus.wdata;
                            state  <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (bus.mem_ack) begin
                        word_q <= merged;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack)
                        state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // mem_req spans READ and WRITE without a gap; only mem_we flips between them.
    assign bus.busy      = (state == S_READ) || (state == S_WRITE);
    assign bus.mem_req   = (state == S_READ) || (state == S_WRITE);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.done      = (state == S_DONE);
    assign bus.addr_err  = (state == S_DONE) && err_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = word_q;
endmodule
